mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/MADD/MSUB/DIV sequencer for the EX stage.
// Latches operands, runs a multiply countdown or a restoring divide,
// performs the HI/LO accumulate step and stalls the pipe until done.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i, op_i     request (held until consumed) and operation code
//   opdata1_i/2_i     rs/dividend, rt/divisor
//   hilo_i            forwarded {HI,LO}, sampled in the accumulate cycle
//   annul_i           flush, aborts any operation
//   result_o          {HI,LO}; divide gives {remainder, quotient}
//   ready_o, busy_o   result valid, sequencer not idle
//   stallreq_o        stall request to pipeline control
//   div_zero_o        last divide had a zero divisor
module mdu_ctrl #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic [63:0] hilo_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        stallreq_o,
  output logic        div_zero_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_DIV,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [63:0] prod_q, prod_d;
  logic [63:0] div_q, div_d;
  logic [63:0] res_q, res_d;
  logic        dz_q, dz_d;

  logic        sgn_in, is_div_in;
  logic        neg_a_in, neg_b_in;
  logic [31:0] a_abs, b_abs;
  logic        sgn_q, neg_q;
  logic [63:0] mul_raw, mul_res, acc_res;
  logic [64:0] div_sh;
  logic [32:0] trial;
  logic [63:0] div_nxt;
  logic [31:0] q_fin, r_fin;

  // Signed ops have an even opcode; DIV/DIVU are 6/7.
  assign sgn_in    = ~op_i[0];
  assign is_div_in = op_i[2] & op_i[1];
  assign neg_a_in  = sgn_in & opdata1_i[31];
  assign neg_b_in  = sgn_in & opdata2_i[31];
  assign a_abs     = neg_a_in ? (32'd0 - opdata1_i) : opdata1_i;
  assign b_abs     = neg_b_in ? (32'd0 - opdata2_i) : opdata2_i;

  assign sgn_q   = ~op_q[0];
  assign neg_q   = sgn_q & (sa_q ^ sb_q);
  assign mul_raw = {32'd0, a_q} * {32'd0, b_q};
  assign mul_res = neg_q ? (64'd0 - mul_raw) : mul_raw;
  assign acc_res = op_q[2] ? (hilo_i - prod_q) : (hilo_i + prod_q);

  // One restoring step: shift {rem,quo} left, try rem - divisor.
  // The partial remainder stays below the divisor, so 32 bits hold it.
  assign div_sh  = {div_q, 1'b0};
  assign trial   = div_sh[64:32] - {1'b0, b_q};
  assign div_nxt = trial[32] ? div_sh[63:0]
                             : {trial[31:0], div_sh[31:1], 1'b1};
  assign q_fin   = neg_q ? (32'd0 - div_nxt[31:0]) : div_nxt[31:0];
  assign r_fin   = (sgn_q & sa_q) ? (32'd0 - div_nxt[63:32])
                                  : div_nxt[63:32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    prod_d  = prod_q;
    div_d   = div_q;
    res_d   = res_q;
    dz_d    = dz_q;
    if (annul_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_d = op_i;
            a_d  = a_abs;
            b_d  = b_abs;
            sa_d = neg_a_in;
            sb_d = neg_b_in;
            dz_d = 1'b0;
            if (!is_div_in) begin
              state_d = S_MUL;
              cnt_d   = 6'(MUL_LAT - 1);
            end else if (opdata2_i == 32'd0) begin
              state_d = S_DONE;
              cnt_d   = '0;
              res_d   = '0;
              dz_d    = 1'b1;
            end else begin
              state_d = S_DIV;
              cnt_d   = 6'(DIV_STEPS - 1);
              div_d   = {32'd0, a_abs};
            end
          end
        end
        S_MUL: begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd0) begin
            cnt_d = '0;
            if (op_q[2:1] == 2'b00) begin
              res_d   = mul_res;
              state_d = S_DONE;
            end else begin
              prod_d  = mul_res;
              state_d = S_ACC;
            end
          end
        end
        S_ACC: begin
          res_d   = acc_res;
          state_d = S_DONE;
        end
        S_DIV: begin
          div_d = div_nxt;
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd0) begin
            cnt_d   = '0;
            res_d   = {r_fin, q_fin};
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (!start_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      prod_q  <= '0;
      div_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      prod_q  <= prod_d;
      div_q   <= div_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  assign result_o   = res_q;
  assign ready_o    = (state_q == S_DONE);
  assign busy_o     = (state_q != S_IDLE);
  assign div_zero_o = dz_q;
  assign stallreq_o = start_i & ~ready_o & ~annul_i;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: bench for the multiply/divide sequencer.
// Transaction-level model plus directed vectors with literal results.
module tb_mdu_ctrl;

  localparam int MUL_LAT   = 2;
  localparam int DIV_STEPS = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] hilo_i = '0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o, busy_o, stallreq_o, div_zero_o;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_STEPS(DIV_STEPS)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hilo_i(hilo_i),
    .annul_i(annul_i), .result_o(result_o), .ready_o(ready_o),
    .busy_o(busy_o), .stallreq_o(stallreq_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural result of one operation, from plain arithmetic.
  function automatic logic [63:0] golden(input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [63:0] hilo);
    longint sa, sb, q, r;
    logic [63:0] sp, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sp = 64'(sa * sb);
    up = {32'd0, a} * {32'd0, b};
    case (op)
      3'd0: return sp;
      3'd1: return up;
      3'd2: return hilo + sp;
      3'd3: return hilo + up;
      3'd4: return hilo - sp;
      3'd5: return hilo - up;
      3'd6: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  // Model: busy from accept to idle, ready after the op's latency.
  bit          m_busy = 0, m_ready = 0, m_dz = 0;
  int          m_left = 0;
  logic [63:0] m_res = '0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_ready = 0; m_left = 0; m_res = '0; m_dz = 0;
    end else if (annul_i) begin
      m_busy = 0; m_ready = 0; m_left = 0;
    end else if (!m_busy) begin
      if (start_i) begin
        m_op = op_i; m_a = opdata1_i; m_b = opdata2_i;
        m_busy = 1; m_dz = 0;
        if (op_i >= 3'd6 && opdata2_i == 32'd0) begin
          m_ready = 1; m_res = '0; m_dz = 1;
        end else if (op_i >= 3'd6) m_left = DIV_STEPS;
        else if (op_i >= 3'd2) m_left = MUL_LAT + 1;
        else m_left = MUL_LAT;
      end
    end else if (m_ready) begin
      if (!start_i) begin
        m_busy = 0; m_ready = 0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        m_res = golden(m_op, m_a, m_b, hilo_i);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", ready_o, m_ready);
      chk("result", result_o, m_res);
      chk("div_zero", div_zero_o, m_dz);
      chk("busy", busy_o, m_busy);
      chk("stall", stallreq_o, start_i & ~m_ready & ~annul_i);
    end
  end

  // Called at posedge+2 with the request already driven.
  task automatic wait_ready(input string nm, input logic [63:0] exp_res,
                            input int exp_lat, input int exp_st);
    int lat = 0;
    int st = 0;
    while (lat < 60) begin
      #1;
      if (stallreq_o) st++;
      @(posedge clk);
      #1;
      lat++;
      if (ready_o) break;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " stall cycles"}, 64'(st), 64'(exp_st));
    chk({nm, " value"}, result_o, exp_res);
  endtask

  task automatic run_op(input string nm, input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [63:0] hilo, input logic [63:0] exp_res,
      input int exp_lat, input int hold);
    @(posedge clk);
    #2;
    start_i = 1; op_i = op; opdata1_i = a; opdata2_i = b; hilo_i = hilo;
    wait_ready(nm, exp_res, exp_lat, exp_lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({nm, " hold ready"}, ready_o, 1);
      chk({nm, " hold value"}, result_o, exp_res);
    end
    #1;
    start_i = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    chk("rst result", result_o, 0);
    chk("rst ready", ready_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst div_zero", div_zero_o, 0);
    #1;
    rst = 0;

    run_op("mult -3x5", 3'd0, 32'hFFFFFFFD, 32'd5, 64'd0,
           64'hFFFFFFFF_FFFFFFF1, 3, 0);
    run_op("maddu", 3'd3, 32'hFFFFFFFF, 32'd2, 64'h10,
           64'h00000002_0000000E, 4, 0);
    run_op("div -7/2", 3'd6, 32'hFFFFFFF9, 32'd2, 64'd0,
           64'hFFFFFFFF_FFFFFFFD, 33, 0);
    run_op("divu 100/7", 3'd7, 32'd100, 32'd7, 64'd0,
           64'h00000002_0000000E, 33, 0);
    run_op("div min/-1", 3'd6, 32'h80000000, 32'hFFFFFFFF, 64'd0,
           64'h00000000_80000000, 33, 0);
    run_op("div 7/-2", 3'd6, 32'd7, 32'hFFFFFFFE, 64'd0,
           64'h00000001_FFFFFFFD, 33, 0);
    run_op("divu 5/0", 3'd7, 32'd5, 32'd0, 64'd0, 64'd0, 1, 0);
    chk("div0 flag", div_zero_o, 1);
    run_op("mult 2x3", 3'd0, 32'd2, 32'd3, 64'd0, 64'd6, 3, 0);
    chk("div0 cleared", div_zero_o, 0);
    run_op("msub -4x3", 3'd4, 32'hFFFFFFFC, 32'd3, 64'd10,
           64'd22, 4, 0);
    run_op("msubu 3x4", 3'd5, 32'd3, 32'd4, 64'd10,
           64'hFFFFFFFF_FFFFFFFE, 4, 0);
    run_op("multu max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0,
           64'hFFFFFFFE_00000001, 3, 0);
    run_op("madd -2x3", 3'd2, 32'hFFFFFFFE, 32'd3, 64'd100,
           64'd94, 4, 0);
    run_op("mult hold", 3'd0, 32'd7, 32'd6, 64'd0, 64'd42, 3, 3);
    @(posedge clk);
    #1;
    chk("hold drop ready", ready_o, 0);
    chk("hold drop busy", busy_o, 0);

    // Flush a divide at step 10, then accept a DIVU straight after.
    #1;
    start_i = 1; op_i = 3'd6; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (11) @(posedge clk);
    #2;
    annul_i = 1;
    @(posedge clk);
    #1;
    chk("annul busy", busy_o, 0);
    chk("annul ready", ready_o, 0);
    chk("annul keeps result", result_o, 64'd42);
    #1;
    annul_i = 0; op_i = 3'd7; opdata1_i = 32'd100; opdata2_i = 32'd7;
    wait_ready("divu after annul", 64'h00000002_0000000E, 33, 33);
    #1;
    start_i = 0;

    // start_i dropped before completion: result still lands.
    @(posedge clk);
    #2;
    start_i = 1; op_i = 3'd1; opdata1_i = 32'd3; opdata2_i = 32'd3;
    @(posedge clk);
    #2;
    start_i = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("early drop result", result_o, 64'd9);
    chk("early drop busy", busy_o, 0);

    // Reset in the accumulate cycle of a MADD.
    #1;
    start_i = 1; op_i = 3'd2; opdata1_i = 32'd2; opdata2_i = 32'd3;
    hilo_i = 64'h10;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-rst busy", busy_o, 1);
    #1;
    rst = 1; start_i = 0;
    @(posedge clk);
    #1;
    chk("mid rst result", result_o, 0);
    chk("mid rst ready", ready_o, 0);
    chk("mid rst busy", busy_o, 0);
    chk("mid rst div_zero", div_zero_o, 0);
    #1;
    rst = 0;
    run_op("mult after rst", 3'd0, 32'd5, 32'hFFFFFFFF, 64'd0,
           64'hFFFFFFFF_FFFFFFFB, 3, 0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
